line_buff_fill: RTL and testbench

// - Fill engine paired with the line buffer controller. On a one-cycle fill request for buffer A or B,

---
 rtl/vga_pkg.sv | 20 ++
 rtl/line_buff_fill.sv | 176 +++++++++++++++++
 tb/tb_line_buff_fill.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA tile definitions used by the line buffer controller and its fill engine.
package vga_pkg;

   localparam int TILE_WIDTH    = 4;
   localparam int TILE_PER_LINE = 640 / TILE_WIDTH;
   localparam int TILE_PER_COL  = 480 / TILE_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fill_state_t;

   // Buffer select bit (0 = A, 1 = B) to one-hot enable.
   function automatic logic [1:0] buf_onehot(input logic sel_b);
      return sel_b ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/line_buff_fill.sv
// Fill engine: copies one row of tiles from frame memory into line buffer A or B,
// tracking the tile row itself and restarting at row 0 on frame start.
module line_buff_fill #(
   parameter  int WIDTH_PX       = 640,
   parameter  int HEIGHT_LNS     = 480,
   parameter  int TILE_WIDTH     = vga_pkg::TILE_WIDTH,
   parameter  int PXL_WIDTH      = 12,
   localparam int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
   localparam int TILE_PER_COL   = HEIGHT_LNS / TILE_WIDTH,
   localparam int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
   localparam int MEM_ADDR_WIDTH = $clog2(TILE_PER_LINE * TILE_PER_COL)
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [1:0]                buff_fill_req_i,
   input  logic                      frame_start_i,
   output logic                      mem_ren_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [PXL_WIDTH-1:0]      mem_rdata_i,
   output logic [1:0]                buff_wen_o,
   output logic [TILE_CTR_WIDTH-1:0] buff_addr_o,
   output logic [PXL_WIDTH-1:0]      buff_wdata_o,
   output logic [1:0]                buff_fill_done_o,
   output logic                      busy_o
);
   import vga_pkg::*;

   localparam int ROW_WIDTH = $clog2(TILE_PER_COL);
   localparam logic [TILE_CTR_WIDTH-1:0] LAST_COL = TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
   localparam logic [ROW_WIDTH-1:0]      LAST_ROW = ROW_WIDTH'(TILE_PER_COL - 1);
   localparam logic [MEM_ADDR_WIDTH-1:0] ROW_STEP = MEM_ADDR_WIDTH'(TILE_PER_LINE);

   fill_state_t               state_r;
   logic                      tgt_b_r;
   logic [TILE_CTR_WIDTH-1:0] col_r;
   logic [TILE_CTR_WIDTH-1:0] rd_col_r;
   logic [MEM_ADDR_WIDTH-1:0] base_r;
   logic [ROW_WIDTH-1:0]      row_r;
   logic [1:0]                pending_r;
   logic                      sync_r;

   logic [1:0]                req_eff_s;
   logic                      start_s;
   logic                      start_b_s;
   logic [1:0]                tgt_oh_s;
   logic                      last_col_s;
   logic [MEM_ADDR_WIDTH-1:0] rd_addr_s;

   // Request arbitration (A before B) and read address generation.
   always_comb begin
      req_eff_s  = pending_r | buff_fill_req_i;
      start_s    = 1'b0;
      start_b_s  = ~req_eff_s[0];
      tgt_oh_s   = buf_onehot(tgt_b_r);
      last_col_s = (col_r == LAST_COL);
      rd_addr_s  = base_r + MEM_ADDR_WIDTH'(col_r);
      if (state_r == IDLE) begin
         start_s = (req_eff_s != 2'b00);
      end else begin
         start_s = 1'b0;
      end
   end

   assign busy_o = (state_r != IDLE);

   // Frame memory data is already registered by the memory; writing it straight
   // through keeps the write exactly one cycle behind the read.
   assign buff_wdata_o = (buff_wen_o != 2'b00) ? mem_rdata_i : {PXL_WIDTH{1'b0}};

   // Fill sequencer with registered read and done outputs.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_r          <= IDLE;
         tgt_b_r          <= 1'b0;
         col_r            <= '0;
         rd_col_r         <= '0;
         mem_ren_o        <= 1'b0;
         mem_addr_o       <= '0;
         buff_fill_done_o <= 2'b00;
      end else begin
         mem_ren_o        <= 1'b0;
         mem_addr_o       <= '0;
         buff_fill_done_o <= 2'b00;
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r <= FETCH;
                  tgt_b_r <= start_b_s;
                  col_r   <= '0;
               end else begin
                  state_r <= IDLE;
               end
            end
            FETCH: begin
               mem_ren_o  <= 1'b1;
               mem_addr_o <= rd_addr_s;
               rd_col_r   <= col_r;
               if (last_col_s) begin
                  col_r   <= '0;
                  state_r <= DRAIN;
               end else begin
                  col_r   <= col_r + TILE_CTR_WIDTH'(1);
               end
            end
            DRAIN: begin
               state_r <= DONE;
            end
            DONE: begin
               buff_fill_done_o <= tgt_oh_s;
               state_r          <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Write pipeline: each read is written to the target buffer one cycle later.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         buff_wen_o  <= 2'b00;
         buff_addr_o <= '0;
      end else if (mem_ren_o) begin
         buff_wen_o  <= tgt_oh_s;
         buff_addr_o <= rd_col_r;
      end else begin
         buff_wen_o  <= 2'b00;
         buff_addr_o <= '0;
      end
   end

   // Row base tracking; a frame start seen while busy takes effect at DONE.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         base_r <= '0;
         row_r  <= '0;
         sync_r <= 1'b0;
      end else if (state_r == DONE) begin
         sync_r <= 1'b0;
         if (sync_r || frame_start_i || (row_r == LAST_ROW)) begin
            base_r <= '0;
            row_r  <= '0;
         end else begin
            base_r <= base_r + ROW_STEP;
            row_r  <= row_r + ROW_WIDTH'(1);
         end
      end else if (frame_start_i) begin
         if (state_r == IDLE) begin
            base_r <= '0;
            row_r  <= '0;
            sync_r <= 1'b0;
         end else begin
            sync_r <= 1'b1;
         end
      end else begin
         sync_r <= sync_r;
      end
   end

   // Pending requests; a repeat for the buffer being filled is dropped.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pending_r <= 2'b00;
      end else if (state_r == IDLE) begin
         if (start_s) begin
            pending_r <= req_eff_s & ~buf_onehot(start_b_s);
         end else begin
            pending_r <= 2'b00;
         end
      end else begin
         pending_r <= pending_r | (buff_fill_req_i & ~tgt_oh_s);
      end
   end

endmodule

// File: tb/tb_line_buff_fill.sv
// Directed bench for line_buff_fill: table of fills plus reset/wrap sequences.
module tb_line_buff_fill;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  fill_req;
   logic        frame_start;
   logic        mem_ren;
   logic [14:0] mem_addr;
   logic [11:0] mem_rdata;
   logic [1:0]  buff_wen;
   logic [7:0]  buff_addr;
   logic [11:0] buff_wdata;
   logic [1:0]  done;
   logic        busy;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   typedef struct {
      logic [1:0] req;
      logic [1:0] tgt;
      int         row;
      int         fs_k;
      int         mreq_k;
      logic [1:0] mreq;
   } vec_t;

   vec_t vecs[12];

   line_buff_fill dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .buff_fill_req_i  (fill_req),
      .frame_start_i    (frame_start),
      .mem_ren_o        (mem_ren),
      .mem_addr_o       (mem_addr),
      .mem_rdata_i      (mem_rdata),
      .buff_wen_o       (buff_wen),
      .buff_addr_o      (buff_addr),
      .buff_wdata_o     (buff_wdata),
      .buff_fill_done_o (done),
      .busy_o           (busy)
   );

   always #5 clk = ~clk;

   // Frame memory model: registered read returning the low 12 address bits.
   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= mem_addr[11:0];
   end

   function automatic logic [40:0] outs();
      return {mem_ren, mem_addr, buff_wen, buff_addr, buff_wdata, done, busy};
   endfunction

   task automatic check(input string name, input int k, input logic [40:0] exp);
      logic [40:0] act;
      act = outs();
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s k=%0d got ren=%b addr=%0d wen=%b baddr=%0d wdata=%0d done=%b busy=%b exp ren=%b addr=%0d wen=%b baddr=%0d wdata=%0d done=%b busy=%b",
                  name, k, act[40], act[39:25], act[24:23], act[22:15], act[14:3], act[2:1], act[0],
                  exp[40], exp[39:25], exp[24:23], exp[22:15], exp[14:3], exp[2:1], exp[0]);
      end
   endtask

   // One complete fill; edge 0 is the next rising edge, returns just after edge 162.
   task automatic run_fill(input string name, input logic [1:0] req_v, input logic [1:0] tgt,
                           input int row, input int fs_k, input int mreq_k, input logic [1:0] mreq_v);
      int          base;
      logic        e_ren;
      logic [14:0] e_addr;
      logic [1:0]  e_wen;
      logic [7:0]  e_baddr;
      logic [11:0] e_wdata;
      logic [14:0] wa;
      base        = row * 160;
      fill_req    = req_v;
      frame_start = (fs_k == 0);
      for (int k = 0; k <= 162; k++) begin
         @(posedge clk);
         #1;
         fill_req    = (mreq_k == k + 1) ? mreq_v : 2'b00;
         frame_start = (fs_k == k + 1);
         if (k >= 1) begin
            e_ren   = (k >= 1) && (k <= 160);
            e_addr  = e_ren ? 15'(base + k - 1) : 15'd0;
            e_wen   = ((k >= 2) && (k <= 161)) ? tgt : 2'b00;
            wa      = 15'(base + k - 2);
            e_baddr = (e_wen != 2'b00) ? 8'(k - 2) : 8'd0;
            e_wdata = (e_wen != 2'b00) ? wa[11:0] : 12'd0;
            check(name, k, {e_ren, e_addr, e_wen, e_baddr, e_wdata,
                            (k == 162) ? tgt : 2'b00, (k <= 161)});
         end
      end
   endtask

   initial begin
      rstn        = 1'b0;
      fill_req    = 2'b00;
      frame_start = 1'b0;
      //            req    tgt    row fs  mreq_k mreq
      vecs[0]  = '{2'b01, 2'b01, 0,  -1, -1, 2'b00};
      vecs[1]  = '{2'b10, 2'b10, 1,  -1, -1, 2'b00};
      vecs[2]  = '{2'b11, 2'b01, 2,  -1, -1, 2'b00};
      vecs[3]  = '{2'b00, 2'b10, 3,  -1, -1, 2'b00};
      vecs[4]  = '{2'b10, 2'b10, 4,  -1, -1, 2'b00};
      vecs[5]  = '{2'b01, 2'b01, 5,  80, -1, 2'b00};
      vecs[6]  = '{2'b10, 2'b10, 0,  -1, -1, 2'b00};
      vecs[7]  = '{2'b01, 2'b01, 1,  -1, 50, 2'b01};
      vecs[8]  = '{2'b10, 2'b10, 2,  -1, 50, 2'b01};
      vecs[9]  = '{2'b00, 2'b01, 3,  -1, -1, 2'b00};
      vecs[10] = '{2'b01, 2'b01, 0,   0, -1, 2'b00};
      vecs[11] = '{2'b10, 2'b10, 1,  -1, -1, 2'b00};

      repeat (3) @(posedge clk);
      #1;
      check("reset", 0, 41'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("idle_after_reset", 0, 41'd0);

      for (int i = 0; i < 12; i++) begin
         run_fill($sformatf("vec%0d", i), vecs[i].req, vecs[i].tgt, vecs[i].row,
                  vecs[i].fs_k, vecs[i].mreq_k, vecs[i].mreq);
         if (i == 9) begin
            for (int j = 0; j < 3; j++) begin
               @(posedge clk);
               #1;
               check("no_extra_fill", j, 41'd0);
            end
         end
      end

      // Frame start while idle, then 121 fills to cross the row wrap.
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      check("fs_idle", 0, 41'd0);
      for (int i = 0; i < 121; i++) begin
         run_fill($sformatf("wrap%0d", i), (i % 2 == 1) ? 2'b10 : 2'b01,
                  (i % 2 == 1) ? 2'b10 : 2'b01, i % 120, -1, -1, 2'b00);
      end

      // Reset at column 80 of a fill on row 1.
      fill_req = 2'b01;
      @(posedge clk);
      #1;
      fill_req = 2'b00;
      for (int k = 1; k <= 81; k++) begin
         @(posedge clk);
         #1;
      end
      vec_cnt++;
      if (!(mem_ren === 1'b1 && mem_addr === 15'd240)) begin
         miss_cnt++;
         $display("FAIL col80_read got ren=%b addr=%0d exp ren=1 addr=240", mem_ren, mem_addr);
      end
      rstn = 1'b0;
      #1;
      check("reset_midfill", 0, 41'd0);
      @(posedge clk);
      #1;
      check("reset_hold", 0, 41'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 170; k++) begin
         @(posedge clk);
         #1;
         check("after_abort", k, 41'd0);
      end
      run_fill("restart", 2'b01, 2'b01, 0, -1, -1, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
